// File: rtl/pc_trigger_scoreboard_if.sv
// pc_trigger_scoreboard_if
// Observation bus for the PC-triggered scoreboard: the 7-bit PC display bus,
// one data field per channel and one {inc,dec} request pair per channel.
// The stimulus side drives through the master modport; the scoreboard
// listens through the slave modport.
interface pc_trigger_scoreboard_if #(
  parameter int N_CH   = 2,
  parameter int PC_W   = 7,
  parameter int DATA_W = 8
);
  logic [PC_W-1:0]        PC_IN;
  logic [N_CH*DATA_W-1:0] DATA_IN;
  logic [N_CH*2-1:0]      REQ_IN;

  modport master (output PC_IN, output DATA_IN, output REQ_IN);
  modport slave  (input  PC_IN, input  DATA_IN, input  REQ_IN);
endinterface

// File: rtl/pc_trigger_scoreboard.sv
// pc_trigger_scoreboard
// Multi-channel scoreboard driven by PC entry events. Each channel samples
// its data field on entering its sample address, derives an expected value
// from that sample and the latched {inc,dec} request, and on entering its
// check address compares against the live data field. The comparison result
// resolves one cycle later into saturating test/pass/fail counters, sticky
// per-channel fail flags and a registered report pulse naming the
// lowest-index resolving channel.
// Optional build macro: PCSB_TIMEOUT_EN -- an armed channel that sees no
// check entry within TIMEOUT_CYC cycles resolves as a failed test.
module pc_trigger_scoreboard #(
  parameter int                      N_CH        = 2,
  parameter int                      PC_W        = 7,
  parameter int                      DATA_W      = 8,
  parameter int                      CNT_W       = 16,
  parameter logic [N_CH*PC_W-1:0]    SAMPLE_PCS  = {7'h12, 7'h12},
  parameter logic [N_CH*PC_W-1:0]    CHECK_PCS   = {7'h4B, 7'h4A},
  parameter logic [N_CH*2-1:0]       MODES       = {2'd1, 2'd0},
  parameter logic [N_CH*DATA_W-1:0]  WRAP_MAX    = {8'd2, 8'd31},
  parameter int                      TIMEOUT_CYC = 256
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  pc_trigger_scoreboard_if.slave                      bus,
  output logic [CNT_W-1:0]                            TEST_COUNT,
  output logic [CNT_W-1:0]                            PASS_COUNT,
  output logic [CNT_W-1:0]                            FAIL_COUNT,
  output logic [N_CH-1:0]                             FAIL_CH,
  output logic                                        CHECK_VALID,
  output logic                                        CHECK_PASS,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] CHECK_CH
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Expected value from the sampled data and the latched {inc,dec} pair.
  function automatic logic [DATA_W-1:0] exp_value(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] s_data,
    input logic [1:0]        s_req,
    input logic [DATA_W-1:0] wmax
  );
    logic [DATA_W-1:0] r;
    case (mode)
      2'd0: begin
        case (s_req)
          2'b10:   r = (s_data == wmax) ? s_data : s_data + DATA_W'(1);
          2'b01:   r = (s_data == {DATA_W{1'b0}}) ? s_data : s_data - DATA_W'(1);
          default: r = s_data;
        endcase
      end
      2'd1:    r = s_req[1] ? ((s_data >= wmax) ? {DATA_W{1'b0}} : s_data + DATA_W'(1)) : s_data;
      default: r = s_data;
    endcase
    return r;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W:0]   b
  );
    logic [CNT_W+1:0] sum;
    sum = {2'b00, a} + {1'b0, b};
    return (sum > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [PC_W-1:0] prev_pc_r;
  logic            pc_new_s;
  logic [N_CH-1:0] sample_hit_s;
  logic [N_CH-1:0] check_hit_s;
  logic [N_CH-1:0] in_check_s;
  logic [N_CH-1:0] chk_pass_s;
  logic [N_CH-1:0] timeout_s;
  logic [N_CH-1:0] resolve_s;
  logic [N_CH-1:0] res_pass_s;
  logic [N_CH-1:0] res_fail_s;
  logic [CNT_W:0]  n_res_s;
  logic [CNT_W:0]  n_pass_s;
  logic [CNT_W:0]  n_fail_s;
  logic [CH_W-1:0] rep_ch_s;
  logic            rep_pass_s;

  assign pc_new_s = (prev_pc_r != bus.PC_IN);

`ifdef PCSB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]        state_r;
    logic [DATA_W-1:0] s_data_r;
    logic [1:0]        s_req_r;
    logic              pass_r;
    logic [DATA_W-1:0] data_s;
    logic [1:0]        req_s;

    assign data_s          = bus.DATA_IN[g*DATA_W +: DATA_W];
    assign req_s           = bus.REQ_IN[g*2 +: 2];
    assign sample_hit_s[g] = pc_new_s && (bus.PC_IN == SAMPLE_PCS[g*PC_W +: PC_W]);
    assign check_hit_s[g]  = pc_new_s && (bus.PC_IN == CHECK_PCS[g*PC_W +: PC_W]);
    assign in_check_s[g]   = (state_r == ST_CHECK);
    assign chk_pass_s[g]   = pass_r;

    // Channel FSM: arm on sample entry, compare on check entry, resolve next edge.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        state_r  <= ST_IDLE;
        s_data_r <= {DATA_W{1'b0}};
        s_req_r  <= 2'b00;
        pass_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (sample_hit_s[g] && (req_s != 2'b00)) begin
              state_r  <= ST_ARMED;
              s_data_r <= data_s;
              s_req_r  <= req_s;
            end
          end
          ST_ARMED: begin
            // Check entry wins when sample and check addresses coincide.
            if (check_hit_s[g]) begin
              state_r <= ST_CHECK;
              pass_r  <= (data_s == exp_value(MODES[g*2 +: 2], s_data_r, s_req_r,
                                               WRAP_MAX[g*DATA_W +: DATA_W]));
            end else if (sample_hit_s[g]) begin
              if (req_s != 2'b00) begin
                s_data_r <= data_s;
                s_req_r  <= req_s;
              end else begin
                state_r <= ST_IDLE;
              end
            end else if (timeout_s[g]) begin
              state_r <= ST_IDLE;
            end
          end
          ST_CHECK: state_r <= ST_IDLE;
          default:  state_r <= ST_IDLE;
        endcase
      end
    end

`ifdef PCSB_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_r;

    // A resample restarts the window, so only a quiet ARMED period times out.
    assign timeout_s[g] = (state_r == ST_ARMED) && !check_hit_s[g] && !sample_hit_s[g] &&
                          (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

    // Age of the current sample while ARMED; cleared on every (re)sample.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end else if ((state_r == ST_ARMED) && !sample_hit_s[g]) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
        tmo_cnt_r <= {TMO_W{1'b0}};
      end
    end
`else
    assign timeout_s[g] = 1'b0;
`endif
  end

  assign resolve_s  = in_check_s | timeout_s;
  assign res_pass_s = in_check_s & chk_pass_s;
  assign res_fail_s = resolve_s & ~res_pass_s;

  // Per-edge tallies and the lowest-index resolving channel to report.
  always_comb begin
    n_res_s    = {(CNT_W+1){1'b0}};
    n_pass_s   = {(CNT_W+1){1'b0}};
    n_fail_s   = {(CNT_W+1){1'b0}};
    rep_ch_s   = {CH_W{1'b0}};
    rep_pass_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      n_res_s  = n_res_s  + {{CNT_W{1'b0}}, resolve_s[i]};
      n_pass_s = n_pass_s + {{CNT_W{1'b0}}, res_pass_s[i]};
      n_fail_s = n_fail_s + {{CNT_W{1'b0}}, res_fail_s[i]};
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      rep_ch_s   = resolve_s[i] ? CH_W'(i) : rep_ch_s;
      rep_pass_s = resolve_s[i] ? res_pass_s[i] : rep_pass_s;
    end
  end

  // Previous PC for entry detection; all-ones so the first PC counts as an entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_pc_r <= {PC_W{1'b1}};
    end else begin
      prev_pc_r <= bus.PC_IN;
    end
  end

  // Resolve: counters, sticky fail flags and the registered report pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TEST_COUNT  <= {CNT_W{1'b0}};
      PASS_COUNT  <= {CNT_W{1'b0}};
      FAIL_COUNT  <= {CNT_W{1'b0}};
      FAIL_CH     <= {N_CH{1'b0}};
      CHECK_VALID <= 1'b0;
      CHECK_PASS  <= 1'b0;
      CHECK_CH    <= {CH_W{1'b0}};
    end else begin
      TEST_COUNT  <= sat_add(TEST_COUNT, n_res_s);
      PASS_COUNT  <= sat_add(PASS_COUNT, n_pass_s);
      FAIL_COUNT  <= sat_add(FAIL_COUNT, n_fail_s);
      FAIL_CH     <= FAIL_CH | res_fail_s;
      CHECK_VALID <= |resolve_s;
      CHECK_PASS  <= rep_pass_s;
      CHECK_CH    <= rep_ch_s;
    end
  end

endmodule

// File: tb/tb_pc_trigger_scoreboard.sv
// tb_pc_trigger_scoreboard
// Two scoreboard instances share one observation bus: the default build
// (distinct check addresses) and one whose channels share check address 0x4A
// so both can resolve on the same edge. A behavioural model of both is
// compared against the DUTs every cycle; directed scenarios add literal
// expectations.
module tb_pc_trigger_scoreboard;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  pc_trigger_scoreboard_if #(.N_CH(2), .PC_W(7), .DATA_W(8)) bus ();

  logic [15:0] test1, pass1, fail1, test2, pass2, fail2;
  logic [1:0]  fch1, fch2;
  logic        v1, p1, c1, v2, p2, c2;

  pc_trigger_scoreboard dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .TEST_COUNT(test1), .PASS_COUNT(pass1), .FAIL_COUNT(fail1), .FAIL_CH(fch1),
    .CHECK_VALID(v1), .CHECK_PASS(p1), .CHECK_CH(c1)
  );

  pc_trigger_scoreboard #(.CHECK_PCS({7'h4A, 7'h4A})) dut2 (
    .CLK(CLK), .RESET(RESET), .bus(bus),
    .TEST_COUNT(test2), .PASS_COUNT(pass2), .FAIL_COUNT(fail2), .FAIL_CH(fch2),
    .CHECK_VALID(v2), .CHECK_PASS(p2), .CHECK_CH(c2)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int SAMPLE_PC = 'h12;
  localparam int TMO = 256;
  int cpc [2][2] = '{'{'h4A, 'h4B}, '{'h4A, 'h4A}};
  int mode_of [2] = '{0, 1};
  int wmax_of [2] = '{31, 2};

  int m_armed [2][2], m_sd [2][2], m_sr [2][2], m_pend [2][2], m_pres [2][2], m_age [2][2];
  int m_prev = 127;
  int e_test [2], e_pass [2], e_fail [2], e_fch [2], e_valid [2], e_cpass [2], e_cch [2];

  function automatic int exp_of(input int mode, input int s, input int req, input int wmax);
    int inc, dec;
    inc = (req >> 1) & 1;
    dec = req & 1;
    if (mode == 0) begin
      if (inc == 1 && dec == 0) return (s == wmax) ? s : (s + 1) % 256;
      if (dec == 1 && inc == 0) return (s == 0) ? 0 : s - 1;
      return s;
    end
    if (mode == 1) return (inc == 1) ? ((s >= wmax) ? 0 : (s + 1) % 256) : s;
    return s;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  always @(posedge CLK) begin
    int pc, nr, np, lo;
    int d [2];
    int r [2];
    int res [2];
    int rp [2];
    pc   = int'(bus.PC_IN);
    d[0] = int'(bus.DATA_IN[7:0]);
    d[1] = int'(bus.DATA_IN[15:8]);
    r[0] = int'(bus.REQ_IN[1:0]);
    r[1] = int'(bus.REQ_IN[3:2]);
    if (RESET) begin
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 2; i++) begin
          m_armed[j][i] = 0; m_sd[j][i] = 0; m_sr[j][i] = 0;
          m_pend[j][i] = 0; m_pres[j][i] = 0; m_age[j][i] = 0;
        end
        e_test[j] = 0; e_pass[j] = 0; e_fail[j] = 0; e_fch[j] = 0;
        e_valid[j] = 0; e_cpass[j] = 0; e_cch[j] = 0;
      end
      m_prev = 127;
    end else begin
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < 2; i++) begin
          res[i] = m_pend[j][i];
          rp[i]  = m_pres[j][i];
          if (m_pend[j][i] != 0) begin
            m_pend[j][i] = 0;
          end else if (m_armed[j][i] != 0) begin
            if (pc == cpc[j][i] && pc != m_prev) begin
              m_pend[j][i]  = 1;
              m_pres[j][i]  = (d[i] == exp_of(mode_of[i], m_sd[j][i], m_sr[j][i], wmax_of[i])) ? 1 : 0;
              m_armed[j][i] = 0;
            end else if (pc == SAMPLE_PC && pc != m_prev) begin
              if (r[i] != 0) begin
                m_sd[j][i] = d[i]; m_sr[j][i] = r[i]; m_age[j][i] = 0;
              end else begin
                m_armed[j][i] = 0;
              end
            end
`ifdef PCSB_TIMEOUT_EN
            else if (m_age[j][i] == TMO - 1) begin
              m_armed[j][i] = 0;
              res[i] = 1;
              rp[i]  = 0;
            end else begin
              m_age[j][i]++;
            end
`endif
          end else if (pc == SAMPLE_PC && pc != m_prev && r[i] != 0) begin
            m_armed[j][i] = 1; m_sd[j][i] = d[i]; m_sr[j][i] = r[i]; m_age[j][i] = 0;
          end
        end
        nr = res[0] + res[1];
        np = ((res[0] != 0 && rp[0] != 0) ? 1 : 0) + ((res[1] != 0 && rp[1] != 0) ? 1 : 0);
        e_test[j] = sat16(e_test[j] + nr);
        e_pass[j] = sat16(e_pass[j] + np);
        e_fail[j] = sat16(e_fail[j] + nr - np);
        for (int i = 0; i < 2; i++)
          if (res[i] != 0 && rp[i] == 0) e_fch[j] = e_fch[j] | (1 << i);
        e_valid[j] = (nr > 0) ? 1 : 0;
        lo = (res[0] != 0) ? 0 : 1;
        e_cch[j]   = lo;
        e_cpass[j] = rp[lo];
      end
      m_prev = pc;
    end
  end

  // Compare both DUTs against the model every cycle, away from the clock edge.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m1_test", {16'd0, test1}, e_test[0]);
      chk("m1_pass", {16'd0, pass1}, e_pass[0]);
      chk("m1_fail", {16'd0, fail1}, e_fail[0]);
      chk("m1_fch",  {30'd0, fch1},  e_fch[0]);
      chk("m1_valid", {31'd0, v1},   e_valid[0]);
      if (e_valid[0] != 0) begin
        chk("m1_cpass", {31'd0, p1}, e_cpass[0]);
        chk("m1_cch",   {31'd0, c1}, e_cch[0]);
      end
      chk("m2_test", {16'd0, test2}, e_test[1]);
      chk("m2_pass", {16'd0, pass2}, e_pass[1]);
      chk("m2_fail", {16'd0, fail2}, e_fail[1]);
      chk("m2_fch",  {30'd0, fch2},  e_fch[1]);
      chk("m2_valid", {31'd0, v2},   e_valid[1]);
      if (e_valid[1] != 0) begin
        chk("m2_cpass", {31'd0, p2}, e_cpass[1]);
        chk("m2_cch",   {31'd0, c2}, e_cch[1]);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; return just after the
  // rising edge that consumed them.
  task automatic tick(input int rst, input int pc, input int d0, input int d1,
                      input int r0, input int r1);
    @(negedge CLK);
    RESET       = (rst != 0);
    bus.PC_IN   = 7'(pc);
    bus.DATA_IN = {8'(d1), 8'(d0)};
    bus.REQ_IN  = {2'(r1), 2'(r0)};
    @(posedge CLK);
    #1;
  endtask

  int pcs [5] = '{'h11, 'h12, 'h4A, 'h4B, 'h20};

  initial begin
    int pc, d0, d1, cur_pc;
    bus.PC_IN = 7'h11; bus.DATA_IN = 16'h0000; bus.REQ_IN = 4'h0;
    tick(1, 'h11, 0, 0, 0, 0);
    tick(1, 'h11, 0, 0, 0, 0);
    cmp_en = 1'b1;
    chk("rst_test", {16'd0, test1}, 0);
    chk("rst_fch",  {30'd0, fch1}, 0);
    chk("rst_valid", {31'd0, v1}, 0);

    // ch0 mode 0: inc 7 -> 8
    tick(0, 'h11, 7, 0, 0, 0);
    tick(0, 'h12, 7, 0, 2, 0);
    tick(0, 'h49, 7, 0, 0, 0);
    tick(0, 'h4A, 8, 0, 0, 0);
    tick(0, 'h4A, 8, 0, 0, 0);
    chk("t1_pass",  {16'd0, pass1}, 1);
    chk("t1_test",  {16'd0, test1}, 1);
    chk("t1_valid", {31'd0, v1}, 1);
    chk("t1_ch",    {31'd0, c1}, 0);
    chk("t1_cpass", {31'd0, p1}, 1);

    // saturate at 31, floor at 0, then a failing check
    tick(0, 'h12, 31, 0, 2, 0); tick(0, 'h4A, 31, 0, 0, 0); tick(0, 'h11, 0, 0, 0, 0);
    tick(0, 'h12, 0, 0, 1, 0);  tick(0, 'h4A, 0, 0, 0, 0);  tick(0, 'h11, 0, 0, 0, 0);
    chk("t2_pass", {16'd0, pass1}, 3);
    tick(0, 'h12, 8, 0, 2, 0);  tick(0, 'h4A, 10, 0, 0, 0); tick(0, 'h11, 0, 0, 0, 0);
    chk("t2_fail",  {16'd0, fail1}, 1);
    chk("t2_fch",   {30'd0, fch1}, 1);
    chk("t2_test",  {16'd0, test1}, 4);
    chk("t2_cpass", {31'd0, p1}, 0);

    // ch1 mode 1, wrap at 2
    tick(0, 'h12, 0, 2, 0, 2); tick(0, 'h4B, 0, 0, 0, 0); tick(0, 'h11, 0, 0, 0, 0);
    chk("t3_pass", {16'd0, pass1}, 4);
    chk("t3_ch",   {31'd0, c1}, 1);
    tick(0, 'h12, 0, 1, 0, 2); tick(0, 'h4B, 0, 2, 0, 0); tick(0, 'h11, 0, 0, 0, 0);
    chk("t3_pass2", {16'd0, pass1}, 5);
    tick(0, 'h12, 0, 2, 0, 2); tick(0, 'h4B, 0, 3, 0, 0); tick(0, 'h11, 0, 0, 0, 0);
    chk("t3_fail", {16'd0, fail1}, 2);
    chk("t3_fch",  {30'd0, fch1}, 3);
    chk("t3_test", {16'd0, test1}, 7);

    // PC held at the check address: one resolve only
    tick(0, 'h12, 4, 0, 2, 0);
    for (int k = 0; k < 5; k++) tick(0, 'h4A, 5, 0, 0, 0);
    chk("t4_test", {16'd0, test1}, 8);
    chk("t4_pass", {16'd0, pass1}, 6);

    // reset while armed discards the pending sample
    tick(0, 'h12, 3, 0, 2, 0);
    tick(1, 'h11, 0, 0, 0, 0);
    tick(0, 'h4A, 4, 0, 0, 0);
    tick(0, 'h11, 0, 0, 0, 0);
    chk("t5_test",  {16'd0, test1}, 0);
    chk("t5_pass",  {16'd0, pass1}, 0);
    chk("t5_fail",  {16'd0, fail1}, 0);
    chk("t5_valid", {31'd0, v1}, 0);

    // both channels resolving on one edge (shared check address instance)
    tick(0, 'h12, 3, 1, 2, 2);
    tick(0, 'h4A, 4, 2, 0, 0);
    tick(0, 'h11, 0, 0, 0, 0);
    chk("t6_test2",  {16'd0, test2}, 2);
    chk("t6_pass2",  {16'd0, pass2}, 2);
    chk("t6_ch2",    {31'd0, c2}, 0);
    chk("t6_valid2", {31'd0, v2}, 1);
    chk("t6_test1",  {16'd0, test1}, 1);

    // armed with no check for well over the timeout window
    tick(1, 'h11, 0, 0, 0, 0);
    tick(0, 'h12, 5, 0, 2, 0);
    for (int k = 0; k < 300; k++) tick(0, 'h11, 0, 0, 0, 0);
`ifdef PCSB_TIMEOUT_EN
    chk("t7_fail", {16'd0, fail1}, 1);
    chk("t7_test", {16'd0, test1}, 1);
`else
    chk("t7_fail", {16'd0, fail1}, 0);
    chk("t7_test", {16'd0, test1}, 0);
`endif

    // randomized traffic
    cur_pc = 'h11;
    for (int n = 0; n < 2500; n++) begin
      pc = ($urandom_range(0, 1) == 0) ? cur_pc : pcs[$urandom_range(0, 4)];
      d0 = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 40));
      d1 = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 4));
      tick(($urandom_range(0, 199) == 0) ? 1 : 0, pc, d0, d1,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cur_pc = pc;
    end

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
